// File: rtl/led_fade_ctrl.sv
// ---------------------------------------------------------------------------
// led_fade_ctrl
//   Per-channel brightness sequencer for a bank of external pwm instances.
//   An activity trigger ramps a channel up to full brightness. The channel
//   holds there for HOLD_TICKS fade ticks after the last trigger and then
//   fades back to dark. A single prescaler sets the fade tick rate, and all
//   channels share it.
//
// Parameters
//   CHANNELS   - number of independent LED channels
//   BITS       - brightness width (must match the pwm BITS)
//   STEP_DIV   - clk cycles per fade tick (>= 2)
//   STEP       - brightness change per tick (1 .. 2^BITS-1)
//   HOLD_TICKS - ticks spent at full brightness after the last trigger (>= 1)
//
// Ports
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   enable     - global enable; low forces every channel idle and dark
//   trig       - per-channel activity level, sampled every clk
//   bright     - packed brightness, channel i at [i*BITS +: BITS]
//   active     - per-channel "not idle" flag, registered with the state
//   any_active - OR of active, registered
// ---------------------------------------------------------------------------
module led_fade_ctrl #(
    parameter int CHANNELS   = 4,
    parameter int BITS       = 8,
    parameter int STEP_DIV   = 1024,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [CHANNELS-1:0]      trig,
    output logic [CHANNELS*BITS-1:0] bright,
    output logic [CHANNELS-1:0]      active,
    output logic                     any_active
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0]   PRE_RELOAD = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0]   HOLD_INIT  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0]   HOLD_LAST  = HW'(1);
    localparam logic [BITS-1:0] MAX        = '1;
    localparam logic [BITS-1:0] STEP_B     = BITS'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN
    } state_t;

    // -----------------------------------------------------------------------
    // Shared prescaler and fade tick
    // -----------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (presc_q == '0) && enable;

    always_comb begin
        presc_d = presc_q;
        if (!enable || presc_q == '0) begin
            presc_d = PRE_RELOAD;
        end else begin
            presc_d = presc_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= PRE_RELOAD;
        end else begin
            presc_q <= presc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating brightness arithmetic
    // -----------------------------------------------------------------------
    function automatic logic [BITS-1:0] sat_add(input logic [BITS-1:0] v);
        logic [BITS:0] sum;
        sum = {1'b0, v} + {1'b0, STEP_B};
        return sum[BITS] ? MAX : sum[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] sat_sub(input logic [BITS-1:0] v);
        return (v < STEP_B) ? '0 : (v - STEP_B);
    endfunction

    // -----------------------------------------------------------------------
    // Per-channel state
    // -----------------------------------------------------------------------
    state_t          state_q  [CHANNELS];
    state_t          state_d  [CHANNELS];
    logic [BITS-1:0] bright_q [CHANNELS];
    logic [BITS-1:0] bright_d [CHANNELS];
    logic [HW-1:0]   hold_q   [CHANNELS];
    logic [HW-1:0]   hold_d   [CHANNELS];
    logic [CHANNELS-1:0] active_q, active_d;
    logic                any_active_q;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            bright_d[i] = bright_q[i];
            hold_d[i]   = hold_q[i];

            if (!enable) begin
                state_d[i]  = IDLE;
                bright_d[i] = '0;
                hold_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        bright_d[i] = '0;
                        if (trig[i]) begin
                            state_d[i] = RAMP_UP;
                        end
                    end

                    RAMP_UP: begin
                        if (tick) begin
                            bright_d[i] = sat_add(bright_q[i]);
                            if (sat_add(bright_q[i]) == MAX) begin
                                state_d[i] = HOLD;
                                hold_d[i]  = HOLD_INIT;
                            end
                        end
                    end

                    HOLD: begin
                        bright_d[i] = MAX;
                        // A trigger reload wins over a tick, so a trigger
                        // that stays high can never let the counter expire.
                        if (trig[i]) begin
                            hold_d[i] = HOLD_INIT;
                        end else if (tick) begin
                            if (hold_q[i] == HOLD_LAST) begin
                                state_d[i] = RAMP_DOWN;
                                hold_d[i]  = '0;
                            end else begin
                                hold_d[i] = hold_q[i] - HW'(1);
                            end
                        end
                    end

                    RAMP_DOWN: begin
                        // A retrigger resumes the ramp from the current level.
                        // The tick is dropped in that cycle.
                        if (trig[i]) begin
                            state_d[i] = RAMP_UP;
                        end else if (tick) begin
                            bright_d[i] = sat_sub(bright_q[i]);
                            if (sat_sub(bright_q[i]) == '0) begin
                                state_d[i] = IDLE;
                            end
                        end
                    end

                    default: begin
                        state_d[i]  = IDLE;
                        bright_d[i] = '0;
                        hold_d[i]   = '0;
                    end
                endcase
            end

            active_d[i] = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= IDLE;
                bright_q[i] <= '0;
                hold_q[i]   <= '0;
            end
            active_q     <= '0;
            any_active_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                bright_q[i] <= bright_d[i];
                hold_q[i]   <= hold_d[i];
            end
            active_q     <= active_d;
            any_active_q <= |active_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign bright[g*BITS +: BITS] = bright_q[g];
    end

    assign active     = active_q;
    assign any_active = any_active_q;

endmodule
